// File: rtl/ycbcr_bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ycbcr_bbox_tracker
// Purpose  : Chroma-keys a YCbCr pixel stream into a binary mask and reports
//            the mask bounding box and pixel count once per frame.
// Options  : define BBOX_OVERLAY_EN to draw the previous frame's box on the
//            mask output stream.
// Revision : 1.0 - initial release
// ============================================================================
module ycbcr_bbox_tracker #(
    parameter logic [7:0]  CB_MIN     = 8'd77,
    parameter logic [7:0]  CB_MAX     = 8'd127,
    parameter logic [7:0]  CR_MIN     = 8'd133,
    parameter logic [7:0]  CR_MAX     = 8'd173,
    parameter int          COORD_W    = 12,
    parameter int          MIN_PIXELS = 16
`ifdef BBOX_OVERLAY_EN
    ,
    parameter logic [23:0] BOX_COLOR  = 24'hFF0000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   de_in,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [23:0]            pixel_in,
    output logic                   de_out,
    output logic                   hsync_out,
    output logic                   vsync_out,
    output logic [23:0]            pixel_out,
    output logic                   box_valid,
    output logic [COORD_W-1:0]     box_x_min,
    output logic [COORD_W-1:0]     box_x_max,
    output logic [COORD_W-1:0]     box_y_min,
    output logic [COORD_W-1:0]     box_y_max,
    output logic [2*COORD_W-1:0]   mask_count,
    output logic                   frame_done
);

    localparam logic [COORD_W-1:0]   c_coord_max  = '1;
    localparam logic [2*COORD_W-1:0] c_count_max  = '1;
    localparam logic [2*COORD_W-1:0] c_min_pixels = (2*COORD_W)'(MIN_PIXELS);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } state_t;

    state_t r_state, w_state_nxt;

    logic                 r_de1, r_hs1, r_vs1, r_mask1;
    logic [COORD_W-1:0]   r_x, r_y, r_x1, r_y1;
    logic [COORD_W-1:0]   r_min_x, r_max_x, r_min_y, r_max_y;
    logic [2*COORD_W-1:0] r_count;
    logic [COORD_W-1:0]   w_min_x_nxt, w_max_x_nxt, w_min_y_nxt, w_max_y_nxt;
    logic [2*COORD_W-1:0] w_count_nxt;
    logic                 w_mask, w_vs_in_rise, w_de_fall, w_frame_end;
    logic                 w_hit, w_latch;
    logic [23:0]          w_pixel_nxt;
    logic                 w_unused;

    // Luma does not take part in the chroma key.
    assign w_unused     = ^pixel_in[23:16];
    assign w_mask       = (pixel_in[15:8] >= CB_MIN) && (pixel_in[15:8] <= CB_MAX) &&
                          (pixel_in[7:0]  >= CR_MIN) && (pixel_in[7:0]  <= CR_MAX);
    assign w_vs_in_rise = vsync_in & ~r_vs1;
    assign w_de_fall    = ~de_in & r_de1;
    // Frame end is seen one stage late so the latch lines up with vsync_out.
    assign w_frame_end  = r_vs1 & ~vsync_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else begin
            if (de_in) begin
                if (r_x != c_coord_max) r_x <= r_x + 1'b1;
            end else begin
                r_x <= '0;
            end
            if (w_vs_in_rise)
                r_y <= '0;
            else if (w_de_fall && (r_y != c_coord_max))
                r_y <= r_y + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de1     <= 1'b0;
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
            r_mask1   <= 1'b0;
            r_x1      <= '0;
            r_y1      <= '0;
            de_out    <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            pixel_out <= '0;
        end else begin
            r_de1     <= de_in;
            r_hs1     <= hsync_in;
            r_vs1     <= vsync_in;
            r_mask1   <= w_mask;
            r_x1      <= r_x;
            r_y1      <= r_y;
            de_out    <= r_de1;
            hsync_out <= r_hs1;
            vsync_out <= r_vs1;
            pixel_out <= w_pixel_nxt;
        end
    end

`ifdef BBOX_OVERLAY_EN
    logic w_on_col, w_on_row;
    assign w_on_col = ((r_x1 == box_x_min) || (r_x1 == box_x_max)) &&
                      (r_y1 >= box_y_min) && (r_y1 <= box_y_max);
    assign w_on_row = ((r_y1 == box_y_min) || (r_y1 == box_y_max)) &&
                      (r_x1 >= box_x_min) && (r_x1 <= box_x_max);
`endif

    always_comb begin
        w_pixel_nxt = r_mask1 ? 24'hFFFFFF : 24'h000000;
`ifdef BBOX_OVERLAY_EN
        if (box_valid && r_de1 && (w_on_col || w_on_row)) w_pixel_nxt = BOX_COLOR;
`endif
    end

    // Running statistics fold in the stage-1 pixel, so a pixel coincident
    // with the vsync edge still belongs to the closing frame.
    always_comb begin
        w_hit       = (r_state == ACTIVE) && r_de1 && r_mask1;
        w_min_x_nxt = r_min_x;
        w_max_x_nxt = r_max_x;
        w_min_y_nxt = r_min_y;
        w_max_y_nxt = r_max_y;
        w_count_nxt = r_count;
        if (w_hit) begin
            if (r_x1 < r_min_x) w_min_x_nxt = r_x1;
            if (r_x1 > r_max_x) w_max_x_nxt = r_x1;
            if (r_y1 < r_min_y) w_min_y_nxt = r_y1;
            if (r_y1 > r_max_y) w_max_y_nxt = r_y1;
            if (r_count != c_count_max) w_count_nxt = r_count + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            WAIT_FRAME: if (w_frame_end) w_state_nxt = ACTIVE;
            ACTIVE:     if (w_frame_end) w_latch = 1'b1;
            default:    w_state_nxt = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= WAIT_FRAME;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_latch) begin
            r_min_x <= c_coord_max;
            r_max_x <= '0;
            r_min_y <= c_coord_max;
            r_max_y <= '0;
            r_count <= '0;
        end else begin
            r_min_x <= w_min_x_nxt;
            r_max_x <= w_max_x_nxt;
            r_min_y <= w_min_y_nxt;
            r_max_y <= w_max_y_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            box_valid  <= 1'b0;
            box_x_min  <= '0;
            box_x_max  <= '0;
            box_y_min  <= '0;
            box_y_max  <= '0;
            mask_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_latch;
            if (w_latch) begin
                box_valid  <= (w_count_nxt >= c_min_pixels);
                box_x_min  <= w_min_x_nxt;
                box_x_max  <= w_max_x_nxt;
                box_y_min  <= w_min_y_nxt;
                box_y_max  <= w_max_y_nxt;
                mask_count <= w_count_nxt;
            end
        end
    end

endmodule
`default_nettype wire
